// File: rtl/fixed_point_argmin.sv
// Sequential arg-min over a sweep of NUM_AGENTS signed fixed-point fitness values.
// Optional global-best tracking across sweeps: define FIXED_POINT_ARGMIN_ELITISM_EN.

module fixed_point_comp #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic                    lt_o
);
    assign lt_o = (a_i < b_i);
endmodule

module fixed_point_argmin #(
    parameter int WIDTH      = 8,
    parameter int NUM_AGENTS = 8,
    localparam int IW        = $clog2(NUM_AGENTS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START_IN,
    input  logic [WIDTH-1:0] VALUE_IN,
    input  logic             VALUE_VALID_IN,
    output logic             VALUE_READY_OUT,
    output logic             BUSY_OUT,
    output logic             DONE_OUT,
    output logic             IMPROVED_OUT,
    output logic [WIDTH-1:0] BEST_VALUE_OUT,
    output logic [IW-1:0]    BEST_INDEX_OUT
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t           state_q;
    logic [IW-1:0]    cnt_q;
    logic [WIDTH-1:0] run_best_q;
    logic [IW-1:0]    run_idx_q;
    logic             done_q;
    logic             improved_q;
    logic [WIDTH-1:0] best_q;
    logic [IW-1:0]    best_idx_q;

    logic [WIDTH-1:0] run_best_d;
    logic [IW-1:0]    run_idx_d;
    logic             run_lt;
    logic             xfer;
    logic             last;
    logic             load;

    assign xfer = (state_q == S_SWEEP) && VALUE_VALID_IN;
    assign last = (cnt_q == IW'(NUM_AGENTS - 1));

    fixed_point_comp #(.WIDTH(WIDTH)) u_run_comp (
        .a_i  ($signed(VALUE_IN)),
        .b_i  ($signed(run_best_q)),
        .lt_o (run_lt)
    );

    // First value of a sweep seeds the running best; strict LT keeps the earlier index on ties.
    always_comb begin
        run_best_d = run_best_q;
        run_idx_d  = run_idx_q;
        if (cnt_q == '0 || run_lt) begin
            run_best_d = VALUE_IN;
            run_idx_d  = cnt_q;
        end
    end

`ifdef FIXED_POINT_ARGMIN_ELITISM_EN
    logic elite_vld_q;
    logic elite_lt;

    fixed_point_comp #(.WIDTH(WIDTH)) u_elite_comp (
        .a_i  ($signed(run_best_d)),
        .b_i  ($signed(best_q)),
        .lt_o (elite_lt)
    );

    assign load = !elite_vld_q || elite_lt;

    always_ff @(posedge CLK) begin
        if (RST)
            elite_vld_q <= 1'b0;
        else if (xfer && last)
            elite_vld_q <= 1'b1;
    end
`else
    assign load = 1'b1;
`endif

    // Result registers are written on the last transfer so they are valid during DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_best_q <= '0;
            run_idx_q  <= '0;
            done_q     <= 1'b0;
            improved_q <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    done_q     <= 1'b0;
                    improved_q <= 1'b0;
                    if (START_IN)
                        state_q <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (xfer) begin
                        cnt_q      <= cnt_q + 1'b1;
                        run_best_q <= run_best_d;
                        run_idx_q  <= run_idx_d;
                        if (last) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            improved_q <= load;
                            if (load) begin
                                best_q     <= run_best_d;
                                best_idx_q <= run_idx_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b0;
                    improved_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign VALUE_READY_OUT = (state_q == S_SWEEP);
    assign BUSY_OUT        = (state_q == S_SWEEP) || (state_q == S_DONE);
    assign DONE_OUT        = done_q;
    assign IMPROVED_OUT    = improved_q;
    assign BEST_VALUE_OUT  = best_q;
    assign BEST_INDEX_OUT  = best_idx_q;
endmodule

// File: tb/tb_fixed_point_argmin.sv
// Directed bench for fixed_point_argmin (WIDTH=8, NUM_AGENTS=4).
module tb_fixed_point_argmin;
    localparam int WIDTH = 8;
    localparam int NA    = 4;
    localparam int IW    = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START_IN = 1'b0;
    logic [WIDTH-1:0] VALUE_IN = '0;
    logic             VALUE_VALID_IN = 1'b0;
    logic             VALUE_READY_OUT, BUSY_OUT, DONE_OUT, IMPROVED_OUT;
    logic [WIDTH-1:0] BEST_VALUE_OUT;
    logic [IW-1:0]    BEST_INDEX_OUT;

    int total = 0;
    int passed = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    fixed_point_argmin #(.WIDTH(WIDTH), .NUM_AGENTS(NA)) dut (
        .CLK(CLK), .RST(RST), .START_IN(START_IN), .VALUE_IN(VALUE_IN),
        .VALUE_VALID_IN(VALUE_VALID_IN), .VALUE_READY_OUT(VALUE_READY_OUT),
        .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT), .IMPROVED_OUT(IMPROVED_OUT),
        .BEST_VALUE_OUT(BEST_VALUE_OUT), .BEST_INDEX_OUT(BEST_INDEX_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (VALUE_VALID_IN && VALUE_READY_OUT) xfer_cnt <= xfer_cnt + 1;
        if (DONE_OUT) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(VALUE_READY_OUT), 0);
        chk({tag, "_busy"},  32'(BUSY_OUT), 0);
        chk({tag, "_done"},  32'(DONE_OUT), 0);
        chk({tag, "_impr"},  32'(IMPROVED_OUT), 0);
        chk({tag, "_best"},  32'(BEST_VALUE_OUT), 0);
        chk({tag, "_idx"},   32'(BEST_INDEX_OUT), 0);
    endtask

    task automatic start_sweep();
        START_IN = 1'b1;
        @(negedge CLK);
        START_IN = 1'b0;
    endtask

    // Presents one value (after optional idle gap) and returns at the negedge after its transfer.
    task automatic send(input logic [WIDTH-1:0] v, input int gap);
        int guard;
        VALUE_VALID_IN = 1'b0;
        repeat (gap) @(negedge CLK);
        VALUE_IN = v;
        VALUE_VALID_IN = 1'b1;
        guard = 0;
        while (!VALUE_READY_OUT && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20) chk("send_ready_timeout", 32'(VALUE_READY_OUT), 1);
        @(negedge CLK);
    endtask

    task automatic chk_done(input string tag, input logic [7:0] best, input logic [1:0] idx,
                            input logic impr);
        VALUE_VALID_IN = 1'b0;
        chk({tag, "_done"},  32'(DONE_OUT), 1);
        chk({tag, "_ready"}, 32'(VALUE_READY_OUT), 0);
        chk({tag, "_best"},  32'(BEST_VALUE_OUT), 32'(best));
        chk({tag, "_idx"},   32'(BEST_INDEX_OUT), 32'(idx));
        chk({tag, "_impr"},  32'(IMPROVED_OUT), 32'(impr));
        @(negedge CLK);
        chk({tag, "_done_clr"}, 32'(DONE_OUT), 0);
        chk({tag, "_busy_clr"}, 32'(BUSY_OUT), 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk_reset_outs("rst_held");
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_outs("rst_rel");

        // back-to-back with a tie on -3
        start_sweep();
        chk("s1_ready_after_start", 32'(VALUE_READY_OUT), 1);
        chk("s1_busy_after_start",  32'(BUSY_OUT), 1);
        send(8'd5, 0); send(8'hFD, 0); send(8'd7, 0); send(8'hFD, 0);
        chk("s1_busy_in_done", 32'(BUSY_OUT), 1);
        chk_done("s1", 8'hFD, 2'd1, 1'b1);

        // extremes with random valid gaps
        xfer_cnt = 0; done_cnt = 0;
        start_sweep();
        send(8'd127, 1);
        send(8'h80, int'($urandom_range(0, 2)));
        send(8'd0, int'($urandom_range(0, 2)));
        send(8'd1, int'($urandom_range(0, 2)));
        chk_done("s2", 8'h80, 2'd1, 1'b1);
        repeat (2) @(negedge CLK);
        chk("s2_xfers", 32'(xfer_cnt), 4);
        chk("s2_dones", 32'(done_cnt), 1);

        // valid in IDLE is ignored; START mid-sweep is ignored
        xfer_cnt = 0; done_cnt = 0;
        VALUE_IN = 8'h9C; VALUE_VALID_IN = 1'b1;
        @(negedge CLK);
        chk("s3_idle_ready", 32'(VALUE_READY_OUT), 0);
        @(negedge CLK);
        VALUE_VALID_IN = 1'b0;
        chk("s3_idle_xfers", 32'(xfer_cnt), 0);
        start_sweep();
        send(8'd20, 0);
        START_IN = 1'b1;
        send(8'd30, 0);
        START_IN = 1'b0;
        send(8'd40, 0);
        chk("s3_no_early_done", 32'(DONE_OUT), 0);
        send(8'd50, 0);
        chk_done("s3", 8'd20, 2'd0, 1'b1);
        chk("s3_xfers", 32'(xfer_cnt), 4);

        // reset mid-sweep discards the partial sweep
        done_cnt = 0;
        start_sweep();
        send(8'd1, 0); send(8'd2, 0);
        VALUE_VALID_IN = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_outs("s4_midrst");
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("s4_no_done", 32'(done_cnt), 0);
        start_sweep();
        send(8'd9, 0); send(8'd8, 0); send(8'd7, 0); send(8'd6, 0);
        chk_done("s4", 8'd6, 2'd3, 1'b1);

        // two sweeps: elitism keeps the earlier, better result
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        start_sweep();
        send(8'd5, 0); send(8'hFD, 0); send(8'd7, 0); send(8'd2, 0);
        chk_done("s5a", 8'hFD, 2'd1, 1'b1);
        start_sweep();
        send(8'd10, 0); send(8'd2, 0); send(8'd4, 0); send(8'd6, 0);
`ifdef FIXED_POINT_ARGMIN_ELITISM_EN
        chk_done("s5b", 8'hFD, 2'd1, 1'b0);
`else
        chk_done("s5b", 8'd2, 2'd1, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fixed_point_argmin.md
# fixed_point_argmin

Sequential arg-min stage placed directly downstream of the signed fixed-point comparator in the GOA datapath. It consumes a stream of `NUM_AGENTS` signed fitness values, one per agent. A single `FIXED_POINT_COMP` instance compares each incoming value against the running best. At the end of each population sweep the block reports the minimum value and the index of the agent that produced it, so the position-update logic can select the target grasshopper.

## Interface
- `WIDTH`, 8: fitness word width, signed two's complement fixed-point.
- `NUM_AGENTS`, 8: values per sweep; must be ≥ 2. Index width `IW = $clog2(NUM_AGENTS)`.
- `CLK`  in  1  clock; all logic rises on it.
- `RST`  in  1  reset; synchronous, active-high.
- `START_IN`  in  1  begin a sweep; sampled only in IDLE.
- `VALUE_IN`  in  WIDTH  signed fitness of the current agent.
- `VALUE_VALID_IN`  in  1  `VALUE_IN` is valid.
- `VALUE_READY_OUT`  out  1  block accepts a value; a transfer happens when valid and ready are both high.
- `BUSY_OUT`  out  1  high in SWEEP and DONE.
- `DONE_OUT`  out  1  one-cycle pulse when the sweep result is published.
- `IMPROVED_OUT`  out  1  one-cycle pulse, coincident with `DONE_OUT`, when the published result changed.
- `BEST_VALUE_OUT`  out  WIDTH  published best (minimum) value.
- `BEST_INDEX_OUT`  out  IW  agent index of `BEST_VALUE_OUT`.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - `START_IN`=1 moves to SWEEP.
  - The agent counter clears to 0.
- SWEEP:
  - `VALUE_READY_OUT`=1.
  - On each transfer at counter 0, the running best loads `VALUE_IN` and the running index loads 0 unconditionally.
  - On a transfer at counter k>0, the running best and index are replaced only if the comparator reports `VALUE_IN` < running best (LT), comparing `VALUE_IN` as operand A.
  - Ties keep the earlier index.
  - The counter increments on every transfer.
  - The transfer at counter `NUM_AGENTS-1` moves the FSM to DONE.
- DONE lasts one cycle:
  - `DONE_OUT`=1.
  - The result registers update (see Configuration) and the FSM returns to IDLE.
- `START_IN` in SWEEP or DONE is ignored.
- `VALUE_VALID_IN` in IDLE or DONE is not accepted (ready is low) and has no effect.
- Gaps in `VALUE_VALID_IN` during SWEEP are allowed; the counter advances only on transfers.
- Comparison is full-width signed: `-2^(WIDTH-1)` is the smallest value and `2^(WIDTH-1)-1` the largest. There is no saturation and no arithmetic beyond the compare.
- The running best and index are internal only. Outputs change only in the DONE cycle.

## Timing
- Reset values:
  - Every output is 0: `VALUE_READY_OUT`, `BUSY_OUT`, `DONE_OUT`, `IMPROVED_OUT`, `BEST_VALUE_OUT`, `BEST_INDEX_OUT`.
  - The FSM is in IDLE, the counter is 0, and the elitism valid flag is cleared.
- `START_IN` high at edge t puts the FSM in SWEEP, so `VALUE_READY_OUT` is high from cycle t+1.
- If the last transfer happens at edge t:
  - `DONE_OUT`/`IMPROVED_OUT` are high, and `BEST_*` hold the new values, in the cycle after edge t.
  - `VALUE_READY_OUT` is low in that same cycle.
  - The earliest next `START_IN` is accepted at edge t+2.
- Minimum sweep length is `NUM_AGENTS`+2 cycles (start, N transfers, done).
- Reset mid-sweep or in DONE:
  - The partial sweep is discarded, the FSM goes to IDLE, and outputs return to reset values.
  - No `DONE_OUT` is produced.
- Outputs are registered. `VALUE_READY_OUT` is decoded from the FSM state register only, with no combinational path from `VALUE_VALID_IN`.

## Configuration
- Macro `FIXED_POINT_ARGMIN_ELITISM_EN` compiles in global-best tracking (elitism).
- Without the macro:
  - In DONE, `BEST_*` always load the sweep's running best and index.
  - `IMPROVED_OUT` equals `DONE_OUT`.
- With the macro:
  - In DONE, `BEST_*` load the sweep result only if the elitism valid flag is clear, or the sweep best < `BEST_VALUE_OUT` (strict).
  - `IMPROVED_OUT` pulses only when the load happens.
  - The valid flag is set on the first DONE and cleared only by `RST`.
  - This uses a second `FIXED_POINT_COMP` instance.

## Test plan
All scenarios use WIDTH=8, NUM_AGENTS=4.
- Back-to-back values 5, -3, 7, -3 -> `DONE_OUT` pulses one cycle after the 4th transfer; `BEST_VALUE_OUT`=0xFD (-3); `BEST_INDEX_OUT`=1 (tie keeps earlier); `IMPROVED_OUT`=1.
- Values 127, -128, 0, 1 sent with random valid gaps -> result -128 (0x80) at index 1. Exactly 4 transfers are counted, and `DONE_OUT` occurs once.
- Valid asserted in IDLE -> ready is 0 and the later sweep result is unaffected. `START_IN` pulsed mid-sweep -> ignored, and the sweep completes after 4 transfers.
- `RST` after 2 transfers of a sweep -> all outputs 0 next cycle and no `DONE_OUT`. A fresh sweep 9, 8, 7, 6 then yields 6 at index 3.
- Sweep 1 = 5, -3, 7, 2, then sweep 2 = 10, 2, 4, 6:
  - Macro defined: sweep 2 publishes -3 at index 1 with `IMPROVED_OUT`=0.
  - Macro undefined: sweep 2 publishes 2 at index 1 with `IMPROVED_OUT`=1.
